// File: rtl/flex_down_counter.sv
// Loadable down-counter/timer with a registered single-cycle expiry pulse.
// Define FLEX_DOWN_COUNTER_AUTO_RELOAD_EN to add the auto_reload port (periodic tick mode).
module flex_down_counter #(
    parameter int unsigned NUM_CNT_BITS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    input  logic                    auto_reload,
`endif
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    expired,
    output logic                    zero_flag
);

    if (NUM_CNT_BITS < 2 || NUM_CNT_BITS > 32) begin : g_bad_width
        $error("flex_down_counter: NUM_CNT_BITS must be in 2..32");
    end

    localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;
    localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRun     = 2'b01,
        StExpired = 2'b10
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
    logic                    expired_q, expired_d;
    logic                    reload_en;

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    assign reload_en = auto_reload;
`else
    assign reload_en = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;

        if (clear) begin
            count_d = CntZero;
            state_d = StIdle;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = (load_val != CntZero) ? StRun : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StRun: begin
                    if (count_enable) begin
                        if (count_q > CntOne) begin
                            count_d = count_q - CntOne;
                        end else if (count_q == CntOne) begin
                            expired_d = 1'b1;
                            // A zero reload value would stall in RUN, so it falls back to one-shot.
                            if (reload_en && (reload_q != CntZero)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = CntZero;
                                state_d = StExpired;
                            end
                        end
                    end
                end
                StExpired: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= CntZero;
            reload_q  <= CntZero;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
        end
    end

    assign count_out = count_q;
    assign busy      = (state_q == StRun);
    assign expired   = expired_q;
    assign zero_flag = (count_q == CntZero);

endmodule

// File: tb/tb_flex_down_counter.sv
// Self-checking bench for flex_down_counter: directed literal checks plus a randomized run
// compared every cycle against a behavioural model.
module tb_flex_down_counter;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst, clear, load, count_enable, auto_reload;
    logic [W-1:0] load_val;
    logic [W-1:0] count_out;
    logic         busy, expired, zero_flag;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        .auto_reload  (auto_reload),
`endif
        .count_out    (count_out),
        .busy         (busy),
        .expired      (expired),
        .zero_flag    (zero_flag)
    );

    // Model: a counting value, the last loaded value, a "timing" flag and the pulse.
    logic [W-1:0] m_cnt, m_rel;
    bit           m_run, m_exp, m_ar;

    always @(posedge clk) begin
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        m_ar = auto_reload;
`else
        m_ar = 1'b0;
`endif
        if (rst) begin
            m_cnt = '0; m_rel = '0; m_run = 0; m_exp = 0;
        end else if (clear) begin
            m_cnt = '0; m_run = 0; m_exp = 0;
        end else if (load) begin
            m_cnt = load_val; m_rel = load_val; m_run = (load_val != 0); m_exp = 0;
        end else if (m_run && count_enable) begin
            if (int'(m_cnt) > 1) begin
                m_cnt = m_cnt - 1'b1;
                m_exp = 0;
            end else begin
                m_exp = 1;
                if (m_ar && m_rel != 0) m_cnt = m_rel;
                else begin
                    m_cnt = '0;
                    m_run = 0;
                end
            end
        end else begin
            m_exp = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model count_out", 32'(count_out), 32'(m_cnt));
            check("model busy", 32'(busy), 32'(m_run));
            check("model expired", 32'(expired), 32'(m_exp));
            check("model zero_flag", 32'(zero_flag), 32'(m_cnt == 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int exp_one[4]   = '{3, 2, 1, 0};
    int gap_en[5]    = '{1, 0, 1, 0, 1};
    int gap_cnt[5]   = '{2, 2, 1, 1, 0};

    initial begin
        rst = 1; load = 1; load_val = 5; clear = 0; count_enable = 0; auto_reload = 0;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("reset count", 32'(count_out), 0);
        check("reset busy", 32'(busy), 0);
        check("reset expired", 32'(expired), 0);
        check("reset zero", 32'(zero_flag), 1);
        rst = 0; load = 0;
        cyc();
        check("post-reset count", 32'(count_out), 0);

        // One-shot
        load_val = 4; load = 1;
        cyc();
        load = 0;
        check("oneshot load", 32'(count_out), 4);
        check("oneshot busy", 32'(busy), 1);
        count_enable = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("oneshot count", 32'(count_out), 32'(exp_one[i]));
            check("oneshot expired", 32'(expired), 32'(exp_one[i] == 0));
            check("oneshot busy", 32'(busy), 32'(exp_one[i] != 0));
        end
        cyc();
        check("oneshot pulse end", 32'(expired), 0);
        check("oneshot idle", 32'(busy), 0);
        count_enable = 0;

        // Gapped enable
        load_val = 3; load = 1;
        cyc();
        load = 0;
        for (int i = 0; i < 5; i++) begin
            count_enable = gap_en[i][0];
            cyc();
            check("gap count", 32'(count_out), 32'(gap_cnt[i]));
            check("gap expired", 32'(expired), 32'(i == 4));
        end
        count_enable = 0;

        // Priority
        load_val = 3; load = 1;
        cyc();
        load = 0; count_enable = 1;
        cyc();
        check("prio pre", 32'(count_out), 2);
        load = 1; load_val = 7;
        cyc();
        check("prio load>en", 32'(count_out), 7);
        check("prio busy", 32'(busy), 1);
        clear = 1; load_val = 9;
        cyc();
        clear = 0; load = 0; count_enable = 0;
        check("prio clear>load", 32'(count_out), 0);
        check("prio clear busy", 32'(busy), 0);

        // Zero load
        load_val = 0; load = 1; count_enable = 1;
        cyc();
        load = 0;
        check("zero load count", 32'(count_out), 0);
        check("zero load busy", 32'(busy), 0);
        check("zero load expired", 32'(expired), 0);
        cyc();
        check("zero load no pulse", 32'(expired), 0);

        // Maximum load
        load_val = '1; load = 1;
        cyc();
        load = 0;
        check("max load", 32'(count_out), 32'h0000_FFFF);
        cyc();
        check("max dec", 32'(count_out), 32'h0000_FFFE);
        clear = 1;
        cyc();
        clear = 0;

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        auto_reload = 1; load_val = 2; load = 1;
        cyc();
        load = 0; count_enable = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("auto count", 32'(count_out), (i % 2 == 0) ? 1 : 2);
            check("auto expired", 32'(expired), 32'(i % 2 == 1));
            check("auto busy", 32'(busy), 1);
        end
        count_enable = 0; auto_reload = 0;
`endif

        // Randomized run
        for (int i = 0; i < 4000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            clear        = ($urandom_range(0, 99) < 2);
            load         = ($urandom_range(0, 99) < 10);
            load_val     = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 8));
            count_enable = ($urandom_range(0, 99) < 70);
            auto_reload  = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
